// File: rtl/loader_pkg.sv
// Shared types and widths for the program loader.
// PROGRAM_LOADER_CHECKSUM_EN selects the trailing checksum byte (see program_loader).
package loader_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 9;

  localparam logic [ADDR_W-1:0] START_UNIT_DEF = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/loader_checksum.sv
// 8-bit modular accumulator of payload bytes with a pass check for the trailing byte.
// Instantiated by program_loader only when PROGRAM_LOADER_CHECKSUM_EN is defined.
module loader_checksum
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] data,
  output logic              pass
);

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] sum;

  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + data;
    end
  end

  // the checksum byte passes when it brings the running sum back to zero
  assign sum  = acc + data;
  assign pass = (sum == '0);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader feeding the instruction ROM write port (edit/unit/code/send).
// Define PROGRAM_LOADER_CHECKSUM_EN to require and verify a trailing checksum byte.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_UNIT = START_UNIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              edit,
  output logic [ADDR_W-1:0] unit,
  output logic [DATA_W-1:0] code,
  output logic              send,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  byte_count
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  remaining;
  logic              accept;
  logic              last_byte;

  // abort wins over a byte offered on the same edge
  assign accept    = busy && in_valid && !abort;
  assign last_byte = (remaining == LEN_W'(1));
  assign in_ready  = busy;
  assign edit      = busy || send;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic acc_clr;
  logic acc_add;
  logic csum_pass;

  assign acc_clr = start && !busy;
  assign acc_add = accept && (state == ST_DATA);

  loader_checksum u_checksum (
    .clk  (clk),
    .clr  (acc_clr),
    .add  (acc_add),
    .data (in_data),
    .pass (csum_pass)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      send       <= 1'b0;
      unit       <= START_UNIT;
      code       <= '0;
      byte_count <= '0;
      ptr        <= START_UNIT;
      remaining  <= '0;
    end else begin
      send <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state      <= ST_LEN;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_count <= '0;
            ptr        <= START_UNIT;
          end
        end
        default: begin
          if (abort) begin
            state <= ST_ERR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else if (accept) begin
            case (state)
              ST_LEN: begin
                remaining <= (in_data == '0) ? LEN_W'(256) : {1'b0, in_data};
                state     <= ST_DATA;
              end
              ST_DATA: begin
                unit       <= ptr;
                code       <= in_data;
                send       <= 1'b1;
                ptr        <= ptr + ADDR_W'(1);
                byte_count <= byte_count + LEN_W'(1);
                remaining  <= remaining - LEN_W'(1);
                if (last_byte) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  state <= ST_CSUM;
`else
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`endif
                end
              end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              ST_CSUM: begin
                busy <= 1'b0;
                if (csum_pass) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end else begin
                  state <= ST_ERR;
                  error <= 1'b1;
                end
              end
`endif
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (start unit 00 and F0) checked every cycle
// against a frame-level model, plus literal expectations for each directed scenario.
module tb_program_loader;
  import loader_pkg::*;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, in_valid;
  logic [7:0] in_data;

  logic       irdy[2], edt[2], snd[2], bsy[2], dn[2], er[2];
  logic [7:0] un[2], cd[2];
  logic [8:0] bc[2];

  int checks = 0;
  int passes = 0;

  logic [15:0] wlog0[$];
  logic [15:0] wlog1[$];

  always #5 clk = ~clk;

  program_loader #(.START_UNIT(8'h00)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(irdy[0]), .edit(edt[0]), .unit(un[0]), .code(cd[0]), .send(snd[0]),
    .busy(bsy[0]), .done(dn[0]), .error(er[0]), .byte_count(bc[0])
  );

  program_loader #(.START_UNIT(8'hF0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(irdy[1]), .edit(edt[1]), .unit(un[1]), .code(cd[1]), .send(snd[1]),
    .busy(bsy[1]), .done(dn[1]), .error(er[1]), .byte_count(bc[1])
  );

  // Frame-level model: a session is open, waiting for a header, counting payload bytes
  // left, then possibly owing one checksum byte.
  bit m_open[2], m_hdr[2], m_tail[2], m_send[2], m_done[2], m_err[2];
  int m_left[2], m_sum[2], m_addr[2], m_unit[2], m_code[2], m_cnt[2];

  function automatic int su(input int g);
    return (g == 0) ? 32'h00 : 32'hF0;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst) begin
        m_open[g] = 0; m_hdr[g] = 0; m_tail[g] = 0; m_send[g] = 0;
        m_done[g] = 0; m_err[g] = 0; m_left[g] = 0; m_sum[g] = 0;
        m_addr[g] = su(g); m_unit[g] = su(g); m_code[g] = 0; m_cnt[g] = 0;
      end else begin
        m_send[g] = 0;
        if (!m_open[g]) begin
          if (start) begin
            m_open[g] = 1; m_hdr[g] = 1; m_tail[g] = 0; m_done[g] = 0; m_err[g] = 0;
            m_cnt[g] = 0; m_addr[g] = su(g); m_sum[g] = 0;
          end
        end else if (abort) begin
          m_open[g] = 0; m_err[g] = 1;
        end else if (in_valid) begin
          if (m_hdr[g]) begin
            m_hdr[g]  = 0;
            m_left[g] = (in_data == 8'h00) ? 256 : int'(in_data);
          end else if (m_left[g] > 0) begin
            m_send[g] = 1; m_unit[g] = m_addr[g]; m_code[g] = int'(in_data);
            m_addr[g] = (m_addr[g] + 1) % 256;
            m_cnt[g]  = m_cnt[g] + 1;
            m_sum[g]  = (m_sum[g] + int'(in_data)) % 256;
            m_left[g] = m_left[g] - 1;
            if (m_left[g] == 0) begin
              if (CSUM) m_tail[g] = 1;
              else begin m_open[g] = 0; m_done[g] = 1; end
            end
          end else if (m_tail[g]) begin
            m_tail[g] = 0; m_open[g] = 0;
            if ((m_sum[g] + int'(in_data)) % 256 == 0) m_done[g] = 1;
            else m_err[g] = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [30:0] act, exp;
    for (int g = 0; g < 2; g++) begin
      act = {irdy[g], bsy[g], edt[g], snd[g], dn[g], er[g], un[g], cd[g], bc[g]};
      exp = {m_open[g], m_open[g], m_open[g] | m_send[g], m_send[g], m_done[g], m_err[g],
             m_unit[g][7:0], m_code[g][7:0], m_cnt[g][8:0]};
      checks++;
      if (act !== exp)
        $display("FAIL cycle_dut%0d t=%0t got rdy/bsy/edit/send/done/err/unit/code/cnt=%b %b %b %b %b %b %h %h %0d expected %b %b %b %b %b %b %h %h %0d",
                 g, $time, act[30], act[29], act[28], act[27], act[26], act[25], act[24:17], act[16:9], act[8:0],
                 exp[30], exp[29], exp[28], exp[27], exp[26], exp[25], exp[24:17], exp[16:9], exp[8:0]);
      else passes++;
    end
    if (snd[0]) wlog0.push_back({un[0], cd[0]});
    if (snd[1]) wlog1.push_back({un[1], cd[1]});
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) $display("FAIL %s got %0h expected %0h", nm, act, exp);
    else passes++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic stream(input bq_t q);
    foreach (q[i]) put(q[i]);
  endtask

  task automatic go();
    wlog0.delete();
    wlog1.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic status(input string nm, input int d, input int e, input int c);
    chk({nm, "_done0"}, dn[0], d);
    chk({nm, "_err0"},  er[0], e);
    chk({nm, "_cnt0"},  bc[0], c);
    chk({nm, "_done1"}, dn[1], d);
    chk({nm, "_err1"},  er[1], e);
  endtask

  initial begin
    bq_t q;
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) tick();
    chk("rst_ready", irdy[0], 0);
    chk("rst_unit1", un[1], 8'hF0);
    chk("rst_busy",  bsy[0], 0);
    rst = 1'b1;
    tick();

    // basic frame with a correct checksum
    go();
    q = '{8'h03, 8'h80, 8'h00, 8'h11, 8'h6F};
    stream(q);
    chk("t1_edit_drop", edt[0], 0);
    tick();
    status("t1", 1, 0, 3);
    chk("t1_nwr", wlog0.size(), 3);
    chk("t1_wr0", wlog0[0], 16'h0080);
    chk("t1_wr1", wlog0[1], 16'h0100);
    chk("t1_wr2", wlog0[2], 16'h0211);
    chk("t1_f0_wr0", wlog1[0], 16'hF080);
    chk("t1_f0_wr2", wlog1[2], 16'hF211);

    // bad checksum: writes stay, error only when checksum is checked
    go();
    q = '{8'h03, 8'h80, 8'h00, 8'h11, 8'h70};
    stream(q);
    tick();
    status("t2", CSUM ? 0 : 1, CSUM ? 1 : 0, 3);
    chk("t2_nwr", wlog0.size(), 3);

    // 256-byte frame, unit wraps on the F0 instance
    go();
    q = '{8'h00};
    for (int i = 0; i < 256; i++) q.push_back(8'(i));
    q.push_back(8'h80);
    stream(q);
    tick();
    status("t3", 1, 0, 256);
    chk("t3_cnt1", bc[1], 256);
    chk("t3_nwr1", wlog1.size(), 256);
    chk("t3_wr1_0",   wlog1[0],   16'hF000);
    chk("t3_wr1_15",  wlog1[15],  16'hFF0F);
    chk("t3_wr1_16",  wlog1[16],  16'h0010);
    chk("t3_wr1_255", wlog1[255], 16'hEFFF);

    // stalled stream with a stray start while busy
    go();
    put(8'h04);
    q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    foreach (q[i]) begin
      in_valid = 1'b0;
      start = (i == 1);
      tick();
      start = 1'b0;
      put(q[i]);
    end
    put(8'h76);
    tick();
    status("t4", 1, 0, 4);
    chk("t4_nwr", wlog0.size(), 4);
    chk("t4_wr0", wlog0[0], 16'h00A1);
    chk("t4_wr3", wlog0[3], 16'h03A4);

    // abort with a same-edge byte, then a clean reload
    go();
    q = '{8'h05, 8'h01, 8'h02};
    stream(q);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h03;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    tick();
    status("t5", 0, 1, 2);
    chk("t5_nwr", wlog0.size(), 2);
    chk("t5_edit", edt[0], 0);
    go();
    q = '{8'h01, 8'h55, 8'hAB};
    stream(q);
    tick();
    status("t5b", 1, 0, 1);
    chk("t5b_wr", wlog0[0], 16'h0055);

    // asynchronous reset mid-session
    go();
    q = '{8'h08, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    stream(q);
    #1 rst = 1'b0;
    #1;
    chk("t6_send", snd[0], 0);
    chk("t6_edit", edt[0], 0);
    chk("t6_ready", irdy[0], 0);
    chk("t6_cnt", bc[0], 0);
    chk("t6_unit0", un[0], 8'h00);
    chk("t6_unit1", un[1], 8'hF0);
    chk("t6_code", cd[0], 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t6_noready", irdy[0], 0);
      put(8'h20 + 8'(i));
    end
    tick();
    chk("t6_nwr", wlog0.size(), 4);
    status("t6", 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that sits directly upstream of the instruction ROM. It accepts a framed program image over a valid/ready byte interface and writes it into ROM using the ROM's edit/unit/code/send write port, one byte per accepted input byte. It reports session status (busy, done, error) to the host-side control logic.

## Interface
- START_UNIT, 8'h00: ROM address of the first payload byte.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; opens a load session from IDLE/DONE/ERR.
- abort  input  1  level; ends an open session at the next edge.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts in_data this cycle.
- edit  output  1  ROM programming-mode strobe.
- unit  output  8  ROM write address.
- code  output  8  ROM write data.
- send  output  1  ROM write strobe; one cycle per byte.
- busy  output  1  session open (LEN/DATA/CSUM).
- done  output  1  sticky; last session completed cleanly.
- error  output  1  sticky; last session failed (checksum or abort).
- byte_count  output  9  payload bytes written this session.

## Operation
- Frame: length byte L (L=0 means 256), then L payload bytes, then one checksum byte if CHECKSUM_EN is defined.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + start -> LEN. On entry, clears done, error, byte_count, and the checksum accumulator; sets ptr=START_UNIT.
- start while busy is ignored.
- Handshake: a byte is accepted on an edge where in_valid && in_ready.
  - in_ready = busy.
  - in_valid low stalls the session indefinitely; nothing is written.
- LEN: the accepted byte loads remaining (9 bit; 0 -> 256). State -> DATA.
- DATA, on each accepted byte:
  - register unit=ptr, code=in_data, send=1 for the next cycle only.
  - ptr increments modulo 256 (0xFF wraps to 0x00).
  - byte_count++, remaining--, accumulator += byte (mod 256).
  - On the last byte -> CSUM if CHECKSUM_EN, else -> DONE.
- CSUM: the accepted byte c passes if (acc + c) mod 256 == 0. Pass -> DONE (done=1); fail -> ERR (error=1). Writes already made are not rolled back.
- abort in LEN/DATA/CSUM -> ERR (error=1); no further send. A send already registered still completes. abort has priority over a same-edge accepted byte, which is then discarded.
- edit = busy || send. It covers the final write pulse and drops the cycle after.
- unit and code hold their last values between pulses.

## Timing
- Reset values: in_ready=0, edit=0, send=0, unit=START_UNIT, code=0, busy=0, done=0, error=0, byte_count=0, state=IDLE.
- Reset mid-session aborts immediately; there is no recovery and start is required afterward.
- Latency: byte accepted at edge k -> send high during cycle k..k+1. The ROM writes at edge k+1.
- Throughput: one payload byte per cycle.
- start at edge k -> in_ready high from k+1.
- DONE/ERR are entered at the edge accepting the final byte (or at the abort edge). done/error are visible the following cycle.

## Configuration
- PROGRAM_LOADER_CHECKSUM_EN defined:
  - CSUM state, accumulator, and trailing checksum byte are present.
  - error is raised on mismatch or abort.
- Undefined:
  - no CSUM state; the frame ends after the payload.
  - error is raised only by abort.

## Structure
- loader_pkg holds:
  - state enum (IDLE, LEN, DATA, CSUM, DONE, ERR);
  - byte width 8, address width 8, length width 9;
  - START_UNIT default.
- Sub-module loader_checksum: 8-bit accumulator with clear, add, and zero-check outputs. It is instantiated only under PROGRAM_LOADER_CHECKSUM_EN.

## Test plan
- start; stream 03,80,00,11,6F -> send pulses (unit,code)=(00,80),(01,00),(02,11); then done=1, error=0, byte_count=3, edit low one cycle after the last send.
- Same frame with checksum 70 -> three writes occur; error=1, done=0.
- START_UNIT=F0, L=00, 256 bytes with matching checksum -> unit runs F0..FF,00..EF; byte_count=256; done=1.
- in_valid high only on alternate cycles during DATA -> send only after accepted bytes; units consecutive with no gaps or duplicates.
- abort after two payload bytes -> ERR, error=1, exactly two sends, edit low; a new start then loads cleanly.
- rst low after five payload bytes -> all outputs at reset values asynchronously; later bytes without start are not accepted (in_ready=0).
